// File: rtl/riscv_alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// riscv_alu_seq_pkg
//   Shared opcode encodings, FSM state type and opcode-class decode helpers for
//   the sequential miriscv ALU. Base ALU and branch encodings follow the
//   miriscv defines. The RV-M ops occupy the otherwise unused 5'b10xxx range,
//   so bits [2:0] alone select the multiply/divide variant.
// -----------------------------------------------------------------------------
package riscv_alu_seq_pkg;

  localparam int ALU_OP_W = 5;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SLTS = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_LTS  = 5'b11100;
  localparam logic [4:0] ALU_LTU  = 5'b11110;
  localparam logic [4:0] ALU_GES  = 5'b11101;
  localparam logic [4:0] ALU_GEU  = 5'b11111;
  localparam logic [4:0] ALU_EQ   = 5'b11000;
  localparam logic [4:0] ALU_NE   = 5'b11001;

  localparam logic [4:0] MDU_MUL    = 5'b10000;
  localparam logic [4:0] MDU_MULH   = 5'b10001;
  localparam logic [4:0] MDU_MULHSU = 5'b10010;
  localparam logic [4:0] MDU_MULHU  = 5'b10011;
  localparam logic [4:0] MDU_DIV    = 5'b10100;
  localparam logic [4:0] MDU_DIVU   = 5'b10101;
  localparam logic [4:0] MDU_REM    = 5'b10110;
  localparam logic [4:0] MDU_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_mdu(input logic [ALU_OP_W-1:0] op);
    return (op[4:3] == 2'b10);
  endfunction

  function automatic logic is_branch(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_EQ)  || (op == ALU_NE)  || (op == ALU_LTS) ||
           (op == ALU_LTU) || (op == ALU_GES) || (op == ALU_GEU);
  endfunction

endpackage

// File: rtl/riscv_alu_seq_mdu_iter.sv
// -----------------------------------------------------------------------------
// riscv_mdu_iter
//   Iterative multiply / divide datapath. Both operations work on operand
//   magnitudes; the sign of the result is restored on the way out.
//   Multiply: shift-add, MUL_STEP multiplier bits per cycle, XLEN/MUL_STEP
//   cycles. Divide: restoring, one quotient bit per cycle, XLEN cycles.
//   Ports:
//     clk_i, arstn_i   clock, async active-low reset
//     flush_i          abandon the current operation
//     start_i          load operands (op_i = opcode[2:0]) and begin
//     done_o           high in the cycle of the final iteration
//     result_o         final result, valid while done_o is high
// -----------------------------------------------------------------------------
module riscv_mdu_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int W2 = 2 * XLEN;
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEP - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic            active_q, active_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            hi_q, hi_d;
  logic            rem_sel_q, rem_sel_d;
  logic            neg_q, neg_d;       // negate product / quotient
  logic            neg_r_q, neg_r_d;   // negate remainder
  logic [W2-1:0]   acc_q, acc_d;       // product, or partial remainder in low half
  logic [W2-1:0]   mcand_q, mcand_d;   // shifted multiplicand, or divisor in low half
  logic [XLEN-1:0] shf_q, shf_d;       // multiplier bits, or dividend/quotient shifter

  logic            a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0] mag_a_s, mag_b_s;
  logic            last_s;
  logic [XLEN:0]   rem_sh_s, rem_diff_s;
  logic [W2-1:0]   mul_sum_s, prod_s;
  logic [XLEN-1:0] quo_s, rem_s;

  // Operand sign interpretation and magnitude extraction at start.
  always_comb begin
    a_signed_s = op_i[2] ? ~op_i[0] : ((op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10));
    b_signed_s = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01);
    a_neg_s    = a_signed_s & a_i[XLEN-1];
    b_neg_s    = b_signed_s & b_i[XLEN-1];
    mag_a_s    = a_neg_s ? -a_i : a_i;
    mag_b_s    = b_neg_s ? -b_i : b_i;
  end

  // One iteration step for each operation.
  always_comb begin
    last_s     = active_q && (cnt_q == (is_div_q ? DIV_LAST : MUL_LAST));
    rem_sh_s   = {acc_q[XLEN-1:0], shf_q[XLEN-1]};
    rem_diff_s = rem_sh_s - {1'b0, mcand_q[XLEN-1:0]};
    mul_sum_s  = acc_q;
    for (int k = 0; k < MUL_STEP; k++) begin
      mul_sum_s = mul_sum_s + (shf_q[k] ? (mcand_q << k) : {W2{1'b0}});
    end
  end

  // Next-state: flush, load on start, or iterate while active.
  always_comb begin
    active_d  = active_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    rem_sel_d = rem_sel_q;
    neg_d     = neg_q;
    neg_r_d   = neg_r_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    shf_d     = shf_q;
    if (flush_i) begin
      active_d = 1'b0;
      cnt_d    = {CW{1'b0}};
    end else if (start_i) begin
      active_d  = 1'b1;
      cnt_d     = {CW{1'b0}};
      is_div_d  = op_i[2];
      hi_d      = (op_i[1:0] != 2'b00);
      rem_sel_d = op_i[1];
      neg_d     = op_i[2] ? (a_neg_s ^ (b_signed_s & b_i[XLEN-1])) : (a_neg_s ^ b_neg_s);
      neg_r_d   = a_neg_s;
      acc_d     = {W2{1'b0}};
      if (op_i[2]) begin
        mcand_d = {{XLEN{1'b0}}, mag_b_s};
        shf_d   = mag_a_s;
      end else begin
        mcand_d = {{XLEN{1'b0}}, mag_a_s};
        shf_d   = mag_b_s;
      end
    end else if (active_q) begin
      cnt_d    = cnt_q + CNT_ONE;
      active_d = ~last_s;
      if (is_div_q) begin
        if (rem_sh_s >= {1'b0, mcand_q[XLEN-1:0]}) begin
          acc_d = {{XLEN{1'b0}}, rem_diff_s[XLEN-1:0]};
          shf_d = {shf_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {{XLEN{1'b0}}, rem_sh_s[XLEN-1:0]};
          shf_d = {shf_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_d   = mul_sum_s;
        mcand_d = mcand_q << MUL_STEP;
        shf_d   = shf_q >> MUL_STEP;
      end
    end else begin
      active_d = 1'b0;
    end
  end

  // Result is taken from the final iteration's next-state so that the
  // consumer can capture it on the same edge that completes the op.
  always_comb begin
    prod_s   = neg_q ? -acc_d : acc_d;
    quo_s    = neg_q ? -shf_d : shf_d;
    rem_s    = neg_r_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    done_o   = last_s;
    if (is_div_q) begin
      result_o = rem_sel_q ? rem_s : quo_s;
    end else begin
      result_o = hi_q ? prod_s[W2-1:XLEN] : prod_s[XLEN-1:0];
    end
  end

  // Datapath state registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      active_q  <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      is_div_q  <= 1'b0;
      hi_q      <= 1'b0;
      rem_sel_q <= 1'b0;
      neg_q     <= 1'b0;
      neg_r_q   <= 1'b0;
      acc_q     <= {W2{1'b0}};
      mcand_q   <= {W2{1'b0}};
      shf_q     <= {XLEN{1'b0}};
    end else begin
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      rem_sel_q <= rem_sel_d;
      neg_q     <= neg_d;
      neg_r_q   <= neg_r_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      shf_q     <= shf_d;
    end
  end

endmodule

// File: rtl/riscv_alu_seq.sv
// -----------------------------------------------------------------------------
// riscv_alu_seq
//   Handshaked execute-stage ALU: RV32I ALU/branch-compare ops in one cycle,
//   RV-M multiply/divide through the iterative riscv_mdu_iter datapath.
//   One op in flight; results are held until the consumer accepts them.
//   Ports:
//     clk_i, arstn_i         clock, async active-low reset
//     flush_i                kill in-flight op (sync, highest priority)
//     valid_i / ready_o      request handshake (ready_o high only when idle)
//     operation_i            5-bit opcode
//     operand_a_i/_b_i       operands, latched at accept
//     valid_o / ready_i      result handshake
//     result_o, flag_o       arithmetic result / branch-compare flag
//     busy_o                 an op is in flight or awaiting acceptance
// -----------------------------------------------------------------------------
module riscv_alu_seq
  import riscv_alu_seq_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [ALU_OP_W-1:0] operation_i,
  input  logic [XLEN-1:0]     operand_a_i,
  input  logic [XLEN-1:0]     operand_b_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [XLEN-1:0]     result_o,
  output logic                flag_o,
  output logic                busy_o
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            flag_q, flag_d;

  logic [SHW-1:0]  shamt_s;
  logic [XLEN-1:0] alu_res_s;
  logic            alu_flag_s;
  logic            div_zero_s, div_ovf_s, div_special_s;
  logic [XLEN-1:0] special_res_s;
  logic            mdu_start_s, mdu_done_s;
  logic [XLEN-1:0] mdu_res_s;

  assign shamt_s = operand_b_i[SHW-1:0];

  // Single-cycle base ALU and branch comparator.
  always_comb begin
    alu_res_s  = {XLEN{1'b0}};
    alu_flag_s = 1'b0;
    case (operation_i)
      ALU_ADD:  alu_res_s = operand_a_i + operand_b_i;
      ALU_SUB:  alu_res_s = operand_a_i - operand_b_i;
      ALU_XOR:  alu_res_s = operand_a_i ^ operand_b_i;
      ALU_OR:   alu_res_s = operand_a_i | operand_b_i;
      ALU_AND:  alu_res_s = operand_a_i & operand_b_i;
      ALU_SLL:  alu_res_s = operand_a_i << shamt_s;
      ALU_SRL:  alu_res_s = operand_a_i >> shamt_s;
      ALU_SRA:  alu_res_s = $unsigned($signed(operand_a_i) >>> shamt_s);
      ALU_SLTS: alu_res_s = {{(XLEN-1){1'b0}}, ($signed(operand_a_i) < $signed(operand_b_i))};
      ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (operand_a_i < operand_b_i)};
      ALU_EQ:   alu_flag_s = (operand_a_i == operand_b_i);
      ALU_NE:   alu_flag_s = (operand_a_i != operand_b_i);
      ALU_LTS:  alu_flag_s = ($signed(operand_a_i) < $signed(operand_b_i));
      ALU_GES:  alu_flag_s = ($signed(operand_a_i) >= $signed(operand_b_i));
      ALU_LTU:  alu_flag_s = (operand_a_i < operand_b_i);
      ALU_GEU:  alu_flag_s = (operand_a_i >= operand_b_i);
      default: begin
        alu_res_s  = {XLEN{1'b0}};
        alu_flag_s = 1'b0;
      end
    endcase
  end

  // Divides whose result is known without iterating (x/0 and MIN/-1).
  always_comb begin
    div_zero_s    = (operand_b_i == {XLEN{1'b0}});
    div_ovf_s     = ~operation_i[0] && (operand_a_i == SMIN) && (operand_b_i == {XLEN{1'b1}});
    div_special_s = operation_i[2] && (div_zero_s || div_ovf_s);
    if (div_zero_s) begin
      special_res_s = operation_i[1] ? operand_a_i : {XLEN{1'b1}};
    end else if (div_ovf_s) begin
      special_res_s = operation_i[1] ? {XLEN{1'b0}} : operand_a_i;
    end else begin
      special_res_s = {XLEN{1'b0}};
    end
  end

  // Control FSM: accept, wait for the MDU, hold result until accepted.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flag_d      = flag_q;
    mdu_start_s = 1'b0;
    if (flush_i) begin
      state_d  = ST_IDLE;
      result_d = {XLEN{1'b0}};
      flag_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            if (is_mdu(operation_i) && !div_special_s) begin
              mdu_start_s = 1'b1;
              state_d     = operation_i[2] ? ST_DIV : ST_MUL;
              result_d    = {XLEN{1'b0}};
              flag_d      = 1'b0;
            end else begin
              state_d  = ST_DONE;
              result_d = is_mdu(operation_i) ? special_res_s : alu_res_s;
              flag_d   = is_branch(operation_i) & alu_flag_s;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          if (mdu_done_s) begin
            state_d  = ST_DONE;
            result_d = mdu_res_s;
            flag_d   = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            state_d  = ST_IDLE;
            result_d = {XLEN{1'b0}};
            flag_d   = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          result_d = {XLEN{1'b0}};
          flag_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= ST_IDLE;
      result_q <= {XLEN{1'b0}};
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  riscv_mdu_iter #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_mdu (
    .clk_i    (clk_i),
    .arstn_i  (arstn_i),
    .flush_i  (flush_i),
    .start_i  (mdu_start_s),
    .op_i     (operation_i[2:0]),
    .a_i      (operand_a_i),
    .b_i      (operand_b_i),
    .done_o   (mdu_done_s),
    .result_o (mdu_res_s)
  );

  assign ready_o  = (state_q == ST_IDLE);
  assign valid_o  = (state_q == ST_DONE);
  assign busy_o   = (state_q != ST_IDLE);
  assign result_o = result_q;
  assign flag_o   = flag_q;

endmodule

// File: tb/tb_riscv_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_riscv_alu_seq
//   Self-checking bench: an arithmetic reference model predicts every result,
//   a monitor compares DUT outputs against it each cycle a result is valid,
//   and directed cases pin the model with hand-computed values.
// -----------------------------------------------------------------------------
module tb_riscv_alu_seq;
  import riscv_alu_seq_pkg::*;

  localparam int XLEN = 32;
  localparam int MS   = 2;

  logic        clk_i = 1'b0;
  logic        arstn_i, flush_i, valid_i, ready_i;
  logic [4:0]  operation_i;
  logic [31:0] operand_a_i, operand_b_i;
  logic        ready_o, valid_o, flag_o, busy_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

  riscv_alu_seq #(.XLEN(XLEN), .MUL_STEP(MS)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .operation_i(operation_i), .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .flag_o(flag_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results straight from the arithmetic definitions.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic f);
    longint sa, sb, q;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a}; ub = {32'd0, b};
    r = 32'd0; f = 1'b0;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_XOR:  r = a ^ b;
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_SLL:  r = a << (b % 32);
      ALU_SRL:  r = a >> (b % 32);
      ALU_SRA:  begin q = sa >>> (b % 32); r = q[31:0]; end
      ALU_SLTS: r = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (ua < ub) ? 32'd1 : 32'd0;
      ALU_EQ:   f = (a == b);
      ALU_NE:   f = (a != b);
      ALU_LTS:  f = (sa < sb);
      ALU_GES:  f = (sa >= sb);
      ALU_LTU:  f = (ua < ub);
      ALU_GEU:  f = (ua >= ub);
      MDU_MUL:    begin p = sa * sb; r = p[31:0];  end
      MDU_MULH:   begin p = sa * sb; r = p[63:32]; end
      MDU_MULHSU: begin p = sa * longint'(ub); r = p[63:32]; end
      MDU_MULHU:  begin p = ua * ub; r = p[63:32]; end
      MDU_DIV:  if (b == 32'd0) r = 32'hFFFFFFFF;
                else if (sa == -64'sd2147483648 && sb == -64'sd1) r = a;
                else begin q = sa / sb; r = q[31:0]; end
      MDU_REM:  if (b == 32'd0) r = a;
                else if (sa == -64'sd2147483648 && sb == -64'sd1) r = 32'd0;
                else begin q = sa % sb; r = q[31:0]; end
      MDU_DIVU: if (b == 32'd0) r = 32'hFFFFFFFF; else begin p = ua / ub; r = p[31:0]; end
      MDU_REMU: if (b == 32'd0) r = a; else begin p = ua % ub; r = p[31:0]; end
      default: begin r = 32'd0; f = 1'b0; end
    endcase
  endfunction

  function automatic int exp_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU}) return XLEN / MS + 1;
    if (op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU}) begin
      if (b == 32'd0) return 1;
      if ((op == MDU_DIV || op == MDU_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return XLEN + 1;
    end
    return 1;
  endfunction

  // Monitor: every valid result is compared against the oldest prediction.
  always @(negedge clk_i) begin
    if (arstn_i) begin
      check("busy_vs_ready", {31'd0, busy_o}, {31'd0, ~ready_o});
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'd0, valid_o}, 32'd0);
        end else begin
          check("result", result_o, exp_q[0][32:1]);
          check("flag", {31'd0, flag_o}, {31'd0, exp_q[0][0]});
          if (ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit use_lit, input logic [31:0] lit_r, input logic lit_f);
    logic [31:0] er;
    logic ef;
    int lat;
    model(op, a, b, er, ef);
    @(posedge clk_i); #1;
    operation_i = op; operand_a_i = a; operand_b_i = b; valid_i = 1'b1;
    ready_i = (hold == 0);
    @(negedge clk_i);
    check("ready_before_accept", {31'd0, ready_o}, 32'd1);
    exp_q.push_back({er, ef});
    @(posedge clk_i); #1;
    valid_i = 1'b0; operand_a_i = $urandom; operand_b_i = $urandom; operation_i = 5'($urandom);
    lat = 0;
    do begin @(negedge clk_i); lat++; end while (!valid_o && lat < 200);
    check("latency", lat, exp_latency(op, a, b));
    if (!valid_o) begin
      exp_q.delete();
      ready_i = 1'b1;
      return;
    end
    if (use_lit) begin
      check("lit_result", result_o, lit_r);
      check("lit_flag", {31'd0, flag_o}, {31'd0, lit_f});
    end
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk_i);
        check("hold_valid", {31'd0, valid_o}, 32'd1);
        check("hold_ready", {31'd0, ready_o}, 32'd0);
      end
      @(posedge clk_i); #1 ready_i = 1'b1;
      @(negedge clk_i);
    end
    @(negedge clk_i);
    check("post_hs_valid", {31'd0, valid_o}, 32'd0);
    check("post_hs_ready", {31'd0, ready_o}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  {31'd0, ready_o}, 32'd1);
    check({tag, "_valid"},  {31'd0, valid_o}, 32'd0);
    check({tag, "_busy"},   {31'd0, busy_o},  32'd0);
    check({tag, "_result"}, result_o, 32'd0);
    check({tag, "_flag"},   {31'd0, flag_o},  32'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] op_tab [0:25];

  initial begin
    op_tab = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SRA, ALU_SRL, ALU_SLL,
               ALU_SLTS, ALU_SLTU, ALU_LTS, ALU_LTU, ALU_GES, ALU_GEU, ALU_EQ, ALU_NE,
               MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
               5'b01010, 5'b11010};
    arstn_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    operation_i = 5'd0; operand_a_i = 32'd0; operand_b_i = 32'd0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk_i); arstn_i = 1'b1;

    issue(ALU_ADD, 32'd7, 32'hFFFFFFFD, 0, 1'b1, 32'd4, 1'b0);
    issue(MDU_MULH, 32'h80000000, 32'h80000000, 0, 1'b1, 32'h40000000, 1'b0);
    issue(MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1, 32'hFFFFFFFE, 1'b0);
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 0, 1'b1, 32'hFFFFFFFD, 1'b0);
    issue(MDU_REM, 32'hFFFFFFF9, 32'd2, 0, 1'b1, 32'hFFFFFFFF, 1'b0);
    issue(MDU_DIVU, 32'd5, 32'd0, 0, 1'b1, 32'hFFFFFFFF, 1'b0);
    issue(MDU_REM, 32'd5, 32'd0, 0, 1'b1, 32'd5, 1'b0);
    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 1'b1, 32'h80000000, 1'b0);
    issue(ALU_SRA, 32'h80000000, 32'h00000021, 0, 1'b1, 32'hC0000000, 1'b0);
    issue(ALU_GES, 32'hFFFFFFFF, 32'd1, 0, 1'b1, 32'd0, 1'b0);
    issue(ALU_LTU, 32'hFFFFFFFF, 32'd1, 0, 1'b1, 32'd0, 1'b0);
    issue(ALU_LTS, 32'hFFFFFFFF, 32'd1, 0, 1'b1, 32'd0, 1'b1);
    issue(MDU_MUL, 32'hFFFFFFFD, 32'd5, 5, 1'b1, 32'hFFFFFFF1, 1'b0);

    // Flush part-way through a divide.
    @(posedge clk_i); #1;
    operation_i = MDU_DIV; operand_a_i = 32'd1000; operand_b_i = 32'd7; valid_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_ready", {31'd0, ready_o}, 32'd1);
    repeat (40) begin
      check("flush_no_valid", {31'd0, valid_o}, 32'd0);
      @(negedge clk_i);
    end
    issue(MDU_DIV, 32'd1000, 32'd7, 0, 1'b1, 32'd142, 1'b0);

    // Flush together with a request in idle drops the request.
    @(posedge clk_i); #1;
    operation_i = ALU_ADD; operand_a_i = 32'd1; operand_b_i = 32'd2; valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0; flush_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("flush_idle_valid", {31'd0, valid_o}, 32'd0);
      check("flush_idle_ready", {31'd0, ready_o}, 32'd1);
    end

    // Asynchronous reset in the middle of a multiply.
    @(posedge clk_i); #1;
    operation_i = MDU_MUL; operand_a_i = 32'd123; operand_b_i = 32'd456; valid_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 arstn_i = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk_i); arstn_i = 1'b1;
    issue(MDU_MUL, 32'd123, 32'd456, 0, 1'b1, 32'd56088, 1'b0);

    // Randomised traffic against the model.
    for (int n = 0; n < 80; n++) begin
      issue(op_tab[$urandom_range(0, 25)], rnd_operand(), rnd_operand(),
            $urandom_range(0, 2), 1'b0, 32'd0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
